// File: rtl/pong_pkg.sv
// Shared types for the pong datapath: screen geometry, coordinates
// and the row-scan state used by the matrix scanner.
package pong_pkg;

    localparam int SCREEN_DIM = 16;

    typedef logic [3:0] coord_t;

    typedef enum logic {
        BLANK,
        LIT
    } scan_state_t;

endpackage

// File: rtl/row_pattern.sv
// Combinational column pattern for one matrix row: ball cell plus
// the two paddles in the outer columns, clipped at the bottom row.
module row_pattern
    import pong_pkg::*;
#(
    parameter int PADDLE_LEN = 3
) (
    input  coord_t                  row_i,
    input  coord_t                  ball_x_i,
    input  coord_t                  ball_y_i,
    input  coord_t                  paddle_l_i,
    input  coord_t                  paddle_r_i,
    output logic [SCREEN_DIM-1:0]   pat_o
);

    localparam logic [4:0] LEN_M1 = 5'(PADDLE_LEN - 1);

    logic [4:0] r5;
    logic [4:0] pl_top;
    logic [4:0] pr_top;
    logic [4:0] pl_bot;
    logic [4:0] pr_bot;
    logic       hit_l;
    logic       hit_r;

    // Extents are 5 bits wide so a paddle near row 15 clips instead of
    // wrapping around to the top rows.
    assign r5     = {1'b0, row_i};
    assign pl_top = {1'b0, paddle_l_i};
    assign pr_top = {1'b0, paddle_r_i};
    assign pl_bot = pl_top + LEN_M1;
    assign pr_bot = pr_top + LEN_M1;

    assign hit_l = (r5 >= pl_top) && (r5 <= pl_bot);
    assign hit_r = (r5 >= pr_top) && (r5 <= pr_bot);

    always_comb begin
        pat_o = '0;
        if (ball_y_i == row_i) begin
            pat_o[ball_x_i] = 1'b1;
        end
        if (hit_l) begin
            pat_o[0] = 1'b1;
        end
        if (hit_r) begin
            pat_o[SCREEN_DIM-1] = 1'b1;
        end
    end

endmodule

// File: rtl/matrix_scanner.sv
// Row-at-a-time scanner for the 16x16 LED matrix with a blanking gap
// before each row and a per-frame snapshot of ball and paddles.
module matrix_scanner #(
    parameter int DWELL      = 1000,
    parameter int BLANK      = 16,
    parameter int PADDLE_LEN = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ball_x,
    input  logic [3:0]  ball_y,
    input  logic [3:0]  paddle_l,
    input  logic [3:0]  paddle_r,
    output logic [15:0] row_sel,
    output logic [15:0] col_drv,
    output logic        frame_start
);

    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    pong_pkg::scan_state_t state_q;
    pong_pkg::scan_state_t state_d;
    logic [CW-1:0]         phase_q;
    logic [CW-1:0]         phase_d;
    pong_pkg::coord_t      row_q;
    pong_pkg::coord_t      row_d;

    pong_pkg::coord_t bx_q;
    pong_pkg::coord_t by_q;
    pong_pkg::coord_t pl_q;
    pong_pkg::coord_t pr_q;
    pong_pkg::coord_t bx_v;
    pong_pkg::coord_t by_v;
    pong_pkg::coord_t pl_v;
    pong_pkg::coord_t pr_v;

    logic [15:0] row_sel_q;
    logic [15:0] row_sel_d;
    logic [15:0] col_drv_q;
    logic [15:0] col_drv_d;
    logic        frame_start_q;
    logic        frame_start_d;
    logic [15:0] pat;

    // The counters describe the cycle about to be shown; the output
    // registers take its image on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= pong_pkg::BLANK;
            phase_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 1'b1;
        row_d   = row_q;
        unique case (state_q)
            pong_pkg::BLANK: begin
                if (phase_q == BLANK_LAST) begin
                    state_d = pong_pkg::LIT;
                    phase_d = '0;
                end
            end
            pong_pkg::LIT: begin
                if (phase_q == DWELL_LAST) begin
                    state_d = pong_pkg::BLANK;
                    phase_d = '0;
                    row_d   = row_q + 4'd1;
                end
            end
            default: begin
                state_d = pong_pkg::BLANK;
                phase_d = '0;
            end
        endcase
    end

    // Bypass the snapshot on its capture edge so a 1-cycle blank gap
    // still renders row 0 from the new frame's values.
    assign bx_v = frame_start_q ? ball_x   : bx_q;
    assign by_v = frame_start_q ? ball_y   : by_q;
    assign pl_v = frame_start_q ? paddle_l : pl_q;
    assign pr_v = frame_start_q ? paddle_r : pr_q;

    row_pattern #(
        .PADDLE_LEN (PADDLE_LEN)
    ) u_row_pattern (
        .row_i      (row_q),
        .ball_x_i   (bx_v),
        .ball_y_i   (by_v),
        .paddle_l_i (pl_v),
        .paddle_r_i (pr_v),
        .pat_o      (pat)
    );

    always_comb begin
        row_sel_d     = '0;
        col_drv_d     = '0;
        frame_start_d = 1'b0;
        if (state_q == pong_pkg::LIT) begin
            row_sel_d = 16'd1 << row_q;
            col_drv_d = pat;
        end else if ((row_q == 4'd0) && (phase_q == '0)) begin
            frame_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_sel_q     <= '0;
            col_drv_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            row_sel_q     <= row_sel_d;
            col_drv_q     <= col_drv_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bx_q <= '0;
            by_q <= '0;
            pl_q <= '0;
            pr_q <= '0;
        end else if (frame_start_q) begin
            bx_q <= ball_x;
            by_q <= ball_y;
            pl_q <= paddle_l;
            pr_q <= paddle_r;
        end
    end

    assign row_sel     = row_sel_q;
    assign col_drv     = col_drv_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// Directed bench for matrix_scanner with DWELL=4, BLANK=2, PADDLE_LEN=3.
module tb_matrix_scanner;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int PL    = 3;
    localparam int ROWP  = DW + BL;
    localparam int FRAME = 16 * ROWP;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ball_x;
    logic [3:0]  ball_y;
    logic [3:0]  paddle_l;
    logic [3:0]  paddle_r;
    logic [15:0] row_sel;
    logic [15:0] col_drv;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_pat [16];

    matrix_scanner #(
        .DWELL      (DW),
        .BLANK      (BL),
        .PADDLE_LEN (PL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .paddle_l    (paddle_l),
        .paddle_r    (paddle_r),
        .row_sel     (row_sel),
        .col_drv     (col_drv),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, " row_sel"}, row_sel, 16'h0000);
        chk({tag, " col_drv"}, col_drv, 16'h0000);
        chk({tag, " frame_start"}, {15'b0, frame_start}, 16'h0000);
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 16; i++) exp_pat[i] = 16'h0000;
    endtask

    // Checks ncyc cycles of a frame, starting at its frame_start cycle.
    task automatic run_frame(input string tag, input int ncyc,
                             input int chg_cyc, input logic [3:0] chg_bx);
        for (int c = 0; c < ncyc; c++) begin
            int r;
            int ph;
            logic lit;
            r   = c / ROWP;
            ph  = c % ROWP;
            lit = (ph >= BL);
            if (c == chg_cyc) ball_x = chg_bx;
            chk($sformatf("%s c=%0d frame_start", tag, c),
                {15'b0, frame_start}, (c == 0) ? 16'd1 : 16'd0);
            chk($sformatf("%s c=%0d row_sel", tag, c),
                row_sel, lit ? (16'd1 << r) : 16'd0);
            chk($sformatf("%s c=%0d col_drv", tag, c),
                col_drv, lit ? exp_pat[r] : 16'd0);
            tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        ball_x   = 4'd8;
        ball_y   = 4'd8;
        paddle_l = 4'd0;
        paddle_r = 4'd0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_off($sformatf("reset%0d", i));
        end
        reset = 1'b0;
        chk_off("release");
        tick();

        // Frame at cycle 0: ball (8,8), both paddles at rows 0-2
        clear_pat();
        exp_pat[0] = 16'h8001;
        exp_pat[1] = 16'h8001;
        exp_pat[2] = 16'h8001;
        exp_pat[8] = 16'h0100;
        run_frame("reset", FRAME, -1, 4'd0);

        ball_x   = 4'd5;
        ball_y   = 4'd9;
        paddle_l = 4'd6;
        paddle_r = 4'd12;
        clear_pat();
        exp_pat[6]  = 16'h0001;
        exp_pat[7]  = 16'h0001;
        exp_pat[8]  = 16'h0001;
        exp_pat[9]  = 16'h0020;
        exp_pat[12] = 16'h8000;
        exp_pat[13] = 16'h8000;
        exp_pat[14] = 16'h8000;
        run_frame("render", FRAME, -1, 4'd0);

        paddle_l = 4'd14;
        paddle_r = 4'd0;
        clear_pat();
        exp_pat[0]  = 16'h8000;
        exp_pat[1]  = 16'h8000;
        exp_pat[2]  = 16'h8000;
        exp_pat[9]  = 16'h0020;
        exp_pat[14] = 16'h0001;
        exp_pat[15] = 16'h0001;
        run_frame("clip", FRAME, -1, 4'd0);

        // ball_x moves to 10 while row 7 is lit (cycle 45)
        ball_x   = 4'd3;
        ball_y   = 4'd11;
        paddle_l = 4'd6;
        paddle_r = 4'd12;
        clear_pat();
        exp_pat[6]  = 16'h0001;
        exp_pat[7]  = 16'h0001;
        exp_pat[8]  = 16'h0001;
        exp_pat[11] = 16'h0008;
        exp_pat[12] = 16'h8000;
        exp_pat[13] = 16'h8000;
        exp_pat[14] = 16'h8000;
        run_frame("tear", FRAME, 45, 4'd10);

        exp_pat[11] = 16'h0400;
        run_frame("tear_next", FRAME, -1, 4'd0);

        ball_x = 4'd0;
        ball_y = 4'd7;
        clear_pat();
        exp_pat[6]  = 16'h0001;
        exp_pat[7]  = 16'h0001;
        exp_pat[8]  = 16'h0001;
        exp_pat[12] = 16'h8000;
        exp_pat[13] = 16'h8000;
        exp_pat[14] = 16'h8000;
        run_frame("overlap", FRAME, -1, 4'd0);

        // Reset pulse while row 10 is lit
        run_frame("pre_rst", 64, -1, 4'd0);
        chk("row10 lit", row_sel, 16'h0400);
        reset  = 1'b1;
        ball_x = 4'd15;
        ball_y = 4'd15;
        tick();
        chk_off("midrst");
        reset = 1'b0;
        tick();
        exp_pat[15] = 16'h8000;
        run_frame("post_rst", FRAME, -1, 4'd0);
        chk("next frame_start", {15'b0, frame_start}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
